// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, status flags,
// an illegal-opcode error bit and an opaque tag carried with each operation.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_EQL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12
    } op_e;

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_alu;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic             r_err;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_sh;
    logic [2*WIDTH-1:0] w_rol2;
    logic [2*WIDTH-1:0] w_ror2;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

    // Ready depends only on stage occupancy and downstream ready, never on in_valid_i.
    assign w_s2_adv   = !r_s2_v || out_ready_i;
    assign w_s1_adv   = !r_s1_v || w_s2_adv;
    assign in_ready_o = w_s1_adv;

    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    assign w_sh   = r_s1_b[SHW-1:0];
    // Rotates come from a doubled operand so a zero amount naturally returns a.
    assign w_rol2 = {r_s1_a, r_s1_a} << w_sh;
    assign w_ror2 = {r_s1_a, r_s1_a} >> w_sh;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
            end
            OP_SLL:  w_res = r_s1_a << w_sh;
            OP_SRL:  w_res = r_s1_a >> w_sh;
            OP_AND:  w_res = r_s1_a & r_s1_b;
            OP_OR:   w_res = r_s1_a | r_s1_b;
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_EQL:  w_res = {{(WIDTH-1){1'b0}}, (r_s1_a == r_s1_b)};
            OP_SRA:  w_res = $signed(r_s1_a) >>> w_sh;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (r_s1_a < r_s1_b)};
            OP_ROL:  w_res = w_rol2[2*WIDTH-1:WIDTH];
            OP_ROR:  w_res = w_ror2[WIDTH-1:0];
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
            r_s1_tag <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid_i;
            if (in_valid_i) begin
                r_s1_a   <= a_i;
                r_s1_b   <= b_i;
                r_s1_op  <= op_i;
                r_s1_tag <= tag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_v  <= 1'b0;
            r_alu   <= '0;
            r_tag   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_alu   <= w_res;
                r_tag   <= r_s1_tag;
                r_zero  <= (w_res == '0);
                r_neg   <= w_res[MSB];
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
                r_err   <= w_err;
            end
        end
    end

    assign out_valid_o = r_s2_v;
    assign alu_o       = r_alu;
    assign tag_o       = r_tag;
    assign zero_o      = r_zero;
    assign neg_o       = r_neg;
    assign carry_o     = r_carry;
    assign ovf_o       = r_ovf;
    assign err_o       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table through a scoreboard queue,
// plus stall, reset-flush and 16-bit sequences.
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] alu;
        logic [3:0] tag;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        logic       e;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        exp_t       exp;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [3:0]  op_i;
    logic [3:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  alu_o;
    logic [3:0]  tag_o;
    logic        zero_o;
    logic        neg_o;
    logic        carry_o;
    logic        ovf_o;
    logic        err_o;

    logic        inValid16;
    logic        inReady16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  op16;
    logic [3:0]  tagIn16;
    logic        outValid16;
    logic [15:0] alu16;
    logic [3:0]  tagOut16;
    logic        zero16;
    logic        neg16;
    logic        carry16;
    logic        ovf16;
    logic        err16;

    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    vec_t vecs[20];
    exp_t sbq[$];
    logic prevStall = 1'b0;
    logic [20:0] prevSnap = '0;

    alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .op_i(op_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_o(alu_o), .tag_o(tag_o), .zero_o(zero_o), .neg_o(neg_o),
        .carry_o(carry_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    alu_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(inValid16), .in_ready_o(inReady16),
        .a_i(a16), .b_i(b16), .op_i(op16), .tag_i(tagIn16),
        .out_valid_o(outValid16), .out_ready_i(1'b1),
        .alu_o(alu16), .tag_o(tagOut16), .zero_o(zero16), .neg_o(neg16),
        .carry_o(carry16), .ovf_o(ovf16), .err_o(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                input logic [3:0] tag, input logic [7:0] alu,
                                input logic z, input logic n, input logic c, input logic v,
                                input logic e);
        vec_t r;
        r.a = a;
        r.b = b;
        r.op = op;
        r.exp = '{alu: alu, tag: tag, z: z, n: n, c: c, v: v, e: e};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at posedge+1; holds the operation until accepted, scoreboarding it on the accept edge.
    task automatic applyStimulus(input vec_t v, input logic [3:0] tag);
        exp_t e;
        bit   done;
        e = v.exp;
        e.tag = tag;
        done = 1'b0;
        a_i = v.a;
        b_i = v.b;
        op_i = v.op;
        tag_i = tag;
        in_valid_i = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready_o) begin
                sbq.push_back(e);
                accepted++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkOutput();
        exp_t got;
        exp_t want;
        got = {alu_o, tag_o, zero_o, neg_o, carry_o, ovf_o, err_o};
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_output: got %h want none", got);
        end else begin
            want = sbq.pop_front();
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL result tag%0d: got alu=%h tag=%h zncve=%b want alu=%h tag=%h zncve=%b",
                         want.tag, got.alu, got.tag, {got.z, got.n, got.c, got.v, got.e},
                         want.alu, want.tag, {want.z, want.n, want.c, want.v, want.e});
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
        check("drain_empty", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops on each handshake and requires held outputs across stalled cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall)
                check("stall_stable", {11'd0, out_valid_o, alu_o, tag_o, zero_o, neg_o, carry_o, ovf_o, err_o},
                      {11'd0, prevSnap});
            if (out_valid_o && out_ready_i) checkOutput();
            prevStall = out_valid_o && !out_ready_i;
            prevSnap = {out_valid_o, alu_o, tag_o, zero_o, neg_o, carry_o, ovf_o, err_o};
        end
    end

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic [15:0] wantAlu, input logic [3:0] wantNcve, input string name);
        bit seen;
        seen = 1'b0;
        a16 = a;
        b16 = b;
        op16 = op;
        tagIn16 = 4'hA;
        inValid16 = 1'b1;
        @(posedge clk);
        #1;
        inValid16 = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (outValid16) seen = 1'b1;
        end
        check({name, "_valid"}, seen, 1);
        check({name, "_alu"}, alu16, wantAlu);
        check({name, "_ncve"}, {neg16, carry16, ovf16, err16}, wantNcve);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(8'hFF, 8'h01, 4'd0,  4'd3,  8'h00, 1, 0, 1, 0, 0);
        vecs[1]  = mk(8'h80, 8'h01, 4'd1,  4'd1,  8'h7F, 0, 0, 0, 1, 0);
        vecs[2]  = mk(8'h01, 8'h02, 4'd1,  4'd2,  8'hFF, 0, 1, 1, 0, 0);
        vecs[3]  = mk(8'h90, 8'hF3, 4'd8,  4'd4,  8'hF2, 0, 1, 0, 0, 0);
        vecs[4]  = mk(8'h01, 8'h01, 4'd12, 4'd5,  8'h80, 0, 1, 0, 0, 0);
        vecs[5]  = mk(8'hFF, 8'h01, 4'd9,  4'd6,  8'h01, 0, 0, 0, 0, 0);
        vecs[6]  = mk(8'hFF, 8'h01, 4'd10, 4'd7,  8'h00, 1, 0, 0, 0, 0);
        vecs[7]  = mk(8'h12, 8'h34, 4'd14, 4'd8,  8'h00, 1, 0, 0, 0, 1);
        vecs[8]  = mk(8'h81, 8'h0A, 4'd2,  4'd9,  8'h04, 0, 0, 0, 0, 0);
        vecs[9]  = mk(8'h81, 8'h09, 4'd3,  4'd10, 8'h40, 0, 0, 0, 0, 0);
        vecs[10] = mk(8'hF0, 8'h3C, 4'd4,  4'd11, 8'h30, 0, 0, 0, 0, 0);
        vecs[11] = mk(8'hF0, 8'h0C, 4'd5,  4'd12, 8'hFC, 0, 1, 0, 0, 0);
        vecs[12] = mk(8'hAA, 8'hAA, 4'd6,  4'd13, 8'h00, 1, 0, 0, 0, 0);
        vecs[13] = mk(8'h5A, 8'h5A, 4'd7,  4'd14, 8'h01, 0, 0, 0, 0, 0);
        vecs[14] = mk(8'h81, 8'h0C, 4'd11, 4'd15, 8'h18, 0, 0, 0, 0, 0);
        vecs[15] = mk(8'h96, 8'h08, 4'd12, 4'd0,  8'h96, 0, 1, 0, 0, 0);
        vecs[16] = mk(8'hFF, 8'hFF, 4'd15, 4'd1,  8'h00, 1, 0, 0, 0, 1);
        vecs[17] = mk(8'h7F, 8'h01, 4'd0,  4'd2,  8'h80, 0, 1, 0, 1, 0);
        vecs[18] = mk(8'h01, 8'h02, 4'd7,  4'd3,  8'h00, 1, 0, 0, 0, 0);
        vecs[19] = mk(8'h33, 8'h44, 4'd13, 4'd4,  8'h00, 1, 0, 0, 0, 1);

        reset_n = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        a_i = '0;
        b_i = '0;
        op_i = '0;
        tag_i = '0;
        inValid16 = 1'b0;
        a16 = '0;
        b16 = '0;
        op16 = '0;
        tagIn16 = '0;
        #12;
        check("reset_out_valid", out_valid_o, 0);
        check("reset_outputs", {alu_o, tag_o, zero_o, neg_o, carry_o, ovf_o, err_o}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("post_reset_in_ready", in_ready_o, 1);

        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], vecs[i].exp.tag);
        drain();

        // Six back-to-back ops into a stalled sink: two fill the pipe, then ready drops.
        out_ready_i = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 4'(i));
            end
            begin
                repeat (4) @(negedge clk);
                check("stall_accepted", accepted, 2);
                check("stall_in_ready", in_ready_o, 0);
                check("stall_out_valid", out_valid_o, 1);
                @(posedge clk);
                #1;
                out_ready_i = 1'b1;
                @(negedge clk);
                check("full_pipe_no_bubble", in_ready_o, 1);
            end
        join
        drain();

        // Fill both stages, then reset: everything in flight must vanish.
        out_ready_i = 1'b0;
        applyStimulus(vecs[1], 4'd9);
        applyStimulus(vecs[2], 4'd10);
        check("prereset_out_valid", out_valid_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid_o, 0);
        check("async_reset_outputs", {alu_o, tag_o, zero_o, neg_o, carry_o, ovf_o, err_o}, 0);
        check("async_reset_in_ready", in_ready_o, 1);
        sbq.delete();
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_output_after_reset", out_valid_o, 0);
        end
        @(posedge clk);
        #1;

        run16(16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1010, "w16_add_ovf");
        run16(16'h1234, 16'h0014, 4'd2,  16'h2340, 4'b0000, "w16_sll");
        run16(16'h0001, 16'h0013, 4'd12, 16'h2000, 4'b0000, "w16_ror");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the team's 8-bit combinational ALU. Adds generic width, a 4-bit opcode space (signed shift, compares, rotates), status flags, an illegal-op error bit, and a tag passthrough. Uses valid/ready handshakes on both sides so it can sit between an issue queue and a writeback stage with full backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two)
TAG_W, 4, width of the opaque tag carried alongside each operation
SHW, $clog2(WIDTH), derived (localparam): shift-amount bits taken from b_i[SHW-1:0]

Ports:
clk  input  1  clock, all flops on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid_i  input  1  operation present on inputs
in_ready_o  output  1  block accepts operation this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
op_i  input  4  opcode
tag_i  input  TAG_W  tag, returned unchanged with result
out_valid_o  output  1  result present
out_ready_i  input  1  downstream accepts result
alu_o  output  WIDTH  result
tag_o  output  TAG_W  tag of the result
zero_o  output  1  alu_o == 0
neg_o  output  1  alu_o[WIDTH-1]
carry_o  output  1  ADD: carry out; SUB: borrow (a<b unsigned); else 0
ovf_o  output  1  ADD/SUB signed overflow; else 0
err_o  output  1  opcode was illegal

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): both stage valids=0, all output data/flag regs=0; out_valid_o=0. in_ready_o=1 immediately after reset.
- Stage 1 (S1) registers a, b, op, tag on accept (in_valid_i & in_ready_o). Stage 2 (S2) registers computed result, flags, err, tag.
- Latency: accept in cycle N -> out_valid_o in cycle N+2 if no backpressure. Throughput 1 op/cycle.
- Flow control: s2_adv = !s2_v | out_ready_i; s1_adv = !s1_v | s2_adv; in_ready_o = s1_adv (combinational from out_ready_i, no comb path from in_valid_i). S1 data moves to S2 when s1_v & s2_adv. Stalled stages hold contents unchanged; outputs stable while out_valid_o & !out_ready_i.
- No drop, no duplication, in-order. Simultaneous accept at input and output in same cycle with both stages full must proceed without bubble.
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 AND, 5 OR, 6 XOR, 7 EQL ({0..,a==b}), 8 SRA (arith), 9 SLT signed ({0..,a<b}), 10 SLTU, 11 ROL, 12 ROR by b[SHW-1:0]; 13-15 illegal: alu_o=0, zero_o=1, others 0, err_o=1.
- Arithmetic: ADD/SUB computed at WIDTH+1 bits; result truncated to WIDTH, carry_o from bit WIDTH (SUB: 1 = borrow). ovf_o ADD = (a[msb]==b[msb]) & (r[msb]!=a[msb]); SUB = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
- Shift amount: only b_i[SHW-1:0]; upper b bits ignored. Shift/rotate by 0 returns a.
- zero_o/neg_o derived from final alu_o for every legal op.
- Reset mid-operation: all in-flight ops discarded, no output pulse after reset release.

Test Plan:
- WIDTH=8, ADD a=8'hFF b=8'h01 tag=3, out_ready=1 -> 2 cycles later alu_o=8'h00, zero=1, carry=1, ovf=0, tag_o=3.
- SUB a=8'h80 b=8'h01 -> alu_o=8'h7F, ovf=1, carry=0, neg=0; SUB a=8'h01 b=8'h02 -> 8'hFF, carry=1, neg=1.
- SRA a=8'h90 b=8'hF3 -> 8'hF2 (shift 3); ROR a=8'h01 b=1 -> 8'h80; SLT a=8'hFF b=8'h01 -> 1, SLTU same -> 0; op=14 -> alu_o=0, err=1.
- Back-to-back 6 ops with out_ready held 0 from cycle 2 for 4 cycles -> in_ready drops after 2 ops held; outputs stable while stalled; all 6 results emerge in order, tags 0..5 intact.
- Reset_n asserted with both stages valid -> out_valid_o=0 and all outputs 0 asynchronously; no result from pre-reset ops after release.
- WIDTH=16 build: ADD 16'h7FFF+16'h0001 -> 16'h8000, ovf=1, neg=1; SLL by b=16'h0014 uses 4 -> a<<4.
